cdb_arbiter: RTL

Collects completed results from the functional-unit reservation stations (ALU, branch, load, store-address) and broadcasts them on the two common data bus lanes. Those lanes feed every reservation station and the reorder buffer. Each source has a small skid FIFO, and a round-robin arbiter grants up to two distinct sources per cycle. It sits directly downstream of the branch RS and its siblings, and upstream of the ROB and the RS operand-capture logic.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/cdb_src_fifo.sv | 66 ++++++
 rtl/cdb_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: result widths, ROB tag space and CDB source indices.
package cpu_pkg;

  localparam int unsigned TAG_W    = 6;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ROB_SIZE = 16;

  localparam logic [TAG_W-1:0] INVALID_TAG = 6'd16;

  localparam int unsigned SRC_ALU = 0;
  localparam int unsigned SRC_BR  = 1;
  localparam int unsigned SRC_LD  = 2;
  localparam int unsigned SRC_ST  = 3;

  // One completed result waiting for a CDB lane.
  typedef struct packed {
    logic [TAG_W-1:0]  rob;
    logic [DATA_W-1:0] data;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source skid FIFO for completed results: circular buffer with push,
// pop, synchronous flush, registered occupancy and the head entry.
module cdb_src_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_flush,
  input  logic       i_push,
  input  logic       i_pop,
  input  cdb_entry_t i_entry,
  output cdb_entry_t o_head,
  output logic [CW-1:0] o_count,
  output logic [CW-1:0] o_count_nxt_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cdb_entry_t    r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;

  // Occupancy after this edge; push and pop together leave it unchanged.
  always_comb begin
    w_count_nxt = r_count;
    if (i_flush) begin
      w_count_nxt = '0;
    end else if (i_push && !i_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!i_push && i_pop) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // Read/write pointers and occupancy; flush empties the buffer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + AW'(1);
      if (i_pop)  r_rd <= r_rd + AW'(1);
      r_count <= w_count_nxt;
    end
  end

  // Storage array; contents are only meaningful while counted.
  always_ff @(posedge clock) begin
    if (i_push && !i_flush) r_mem[r_wr] <= i_entry;
  end

  assign o_head        = r_mem[r_rd];
  assign o_count       = r_count;
  assign o_count_nxt_c = w_count_nxt;

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers results from each functional-unit RS in a
// skid FIFO and broadcasts up to two distinct sources per cycle on two lanes,
// round-robin. Optional macro CDB_GAP_EN forbids a lane from casting on two
// consecutive cycles (a blocked lane's grant moves to the other lane if free).
module cdb_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [NUM_SRC-1:0]          src_valid,
  input  logic [NUM_SRC*TAG_W-1:0]    src_rob,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  output logic [NUM_SRC-1:0]          src_ready,
  output logic                        cdb1_cast,
  output logic [TAG_W-1:0]            cdb1_rob,
  output logic [DATA_W-1:0]           cdb1_data,
  output logic                        cdb2_cast,
  output logic [TAG_W-1:0]            cdb2_rob,
  output logic [DATA_W-1:0]           cdb2_data,
  output logic                        busy
);

  localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);

  cdb_entry_t         w_in        [NUM_SRC];
  cdb_entry_t         w_head      [NUM_SRC];
  logic [CW-1:0]      w_count     [NUM_SRC];
  logic [CW-1:0]      w_count_nxt [NUM_SRC];
  logic [NUM_SRC-1:0] w_push;
  logic [NUM_SRC-1:0] w_pop;
  logic [NUM_SRC-1:0] w_nonempty;
  logic [NUM_SRC-1:0] w_ready_nxt;
  logic               w_busy_nxt;

  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic [PTR_W-1:0]   w_scan_idx;
  logic               w_first;
  logic [PTR_W-1:0]   w_first_idx;
  logic               w_second;
  logic [PTR_W-1:0]   w_second_idx;
  logic               w_l1_ok;
  logic               w_l2_ok;
  logic               w_g1;
  logic [PTR_W-1:0]   w_g1_idx;
  logic               w_g2;
  logic [PTR_W-1:0]   w_g2_idx;

  logic [NUM_SRC-1:0] r_ready;
  logic               r_busy;
  logic               r_cast1;
  logic [TAG_W-1:0]   r_rob1;
  logic [DATA_W-1:0]  r_data1;
  logic               r_cast2;
  logic [TAG_W-1:0]   r_rob2;
  logic [DATA_W-1:0]  r_data2;

  function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx);
    return (idx == PTR_W'(NUM_SRC - 1)) ? '0 : idx + PTR_W'(1);
  endfunction

  // One FIFO per source; out-of-range tags never enter the buffer.
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    assign w_in[k]       = {src_rob[k*TAG_W +: TAG_W], src_data[k*DATA_W +: DATA_W]};
    assign w_push[k]     = src_valid[k] & r_ready[k] & ~flush
                         & (src_rob[k*TAG_W +: TAG_W] < TAG_W'(ROB_SIZE));
    assign w_nonempty[k] = (w_count[k] != '0);

    cdb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock         (clock),
      .reset         (reset),
      .i_flush       (flush),
      .i_push        (w_push[k]),
      .i_pop         (w_pop[k]),
      .i_entry       (w_in[k]),
      .o_head        (w_head[k]),
      .o_count       (w_count[k]),
      .o_count_nxt_c (w_count_nxt[k])
    );
  end

  // Round-robin scan from the pointer: first two distinct non-empty sources.
  always_comb begin
    w_first      = 1'b0;
    w_first_idx  = '0;
    w_second     = 1'b0;
    w_second_idx = '0;
    w_scan_idx   = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      w_scan_idx = PTR_W'((32'(r_ptr) + i) % NUM_SRC);
      if (w_nonempty[w_scan_idx]) begin
        if (!w_first) begin
          w_first     = 1'b1;
          w_first_idx = w_scan_idx;
        end else if (!w_second) begin
          w_second     = 1'b1;
          w_second_idx = w_scan_idx;
        end
      end
    end
  end

  // Lane assignment, pops and pointer update; flush suppresses all grants.
  always_comb begin
`ifdef CDB_GAP_EN
    w_l1_ok = ~r_cast1;
    w_l2_ok = ~r_cast2;
`else
    w_l1_ok = 1'b1;
    w_l2_ok = 1'b1;
`endif
    w_g1      = 1'b0;
    w_g1_idx  = '0;
    w_g2      = 1'b0;
    w_g2_idx  = '0;
    w_pop     = '0;
    w_ptr_nxt = r_ptr;
    if (!flush) begin
      if (w_l1_ok) begin
        w_g1     = w_first;
        w_g1_idx = w_first_idx;
        if (w_l2_ok) begin
          w_g2     = w_second;
          w_g2_idx = w_second_idx;
        end
      end else if (w_l2_ok) begin
        w_g2     = w_first;
        w_g2_idx = w_first_idx;
      end
    end
    if (w_g1) w_pop[w_g1_idx] = 1'b1;
    if (w_g2) w_pop[w_g2_idx] = 1'b1;
    if (w_g2) begin
      w_ptr_nxt = next_idx(w_g2_idx);
    end else if (w_g1) begin
      w_ptr_nxt = next_idx(w_g1_idx);
    end
  end

  // Next-cycle ready and busy from post-edge occupancy.
  always_comb begin
    w_ready_nxt = '0;
    w_busy_nxt  = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      w_ready_nxt[k] = (w_count_nxt[k] < CW'(FIFO_DEPTH));
      w_busy_nxt     = w_busy_nxt | (w_count_nxt[k] != '0);
    end
  end

  // Output registers and arbitration pointer; idle lanes hold their data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr   <= '0;
      r_ready <= '1;
      r_busy  <= 1'b0;
      r_cast1 <= 1'b0;
      r_rob1  <= INVALID_TAG;
      r_data1 <= '0;
      r_cast2 <= 1'b0;
      r_rob2  <= INVALID_TAG;
      r_data2 <= '0;
    end else begin
      r_ptr   <= w_ptr_nxt;
      r_ready <= w_ready_nxt;
      r_busy  <= w_busy_nxt;
      r_cast1 <= w_g1;
      r_rob1  <= w_g1 ? w_head[w_g1_idx].rob : INVALID_TAG;
      if (w_g1) r_data1 <= w_head[w_g1_idx].data;
      r_cast2 <= w_g2;
      r_rob2  <= w_g2 ? w_head[w_g2_idx].rob : INVALID_TAG;
      if (w_g2) r_data2 <= w_head[w_g2_idx].data;
    end
  end

  assign src_ready = r_ready;
  assign busy      = r_busy;
  assign cdb1_cast = r_cast1;
  assign cdb1_rob  = r_rob1;
  assign cdb1_data = r_data1;
  assign cdb2_cast = r_cast2;
  assign cdb2_rob  = r_rob2;
  assign cdb2_data = r_data2;

endmodule
